sfp_link_supervisor: RTL and testbench

SFP_LINK_SUPERVISOR -- requirements
Module: sfp_link_supervisor

---
 rtl/sfp_link_pkg.sv | 23 ++
 rtl/sfp_level_filter.sv | 34 +++
 rtl/sfp_link_supervisor.sv | 143 ++++++++++++++
 tb/tb_sfp_link_supervisor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sfp_link_pkg.sv
// rtl/sfp_link_pkg.sv - state encoding and default timing for the SFP/Aurora link supervisor
package sfp_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEQ     = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_LINK_UP = 3'd3,
        ST_FAIL    = 3'd4
    } sfp_state_e;

    localparam int unsigned DEF_T_PB_ON     = 100;
    localparam int unsigned DEF_T_PMA_ON    = 300;
    localparam int unsigned DEF_T_PMA_OFF   = 200_050_000;
    localparam int unsigned DEF_T_PB_OFF    = 200_100_000;
    localparam int unsigned DEF_T_INIT_DONE = 200_200_000;
    localparam int unsigned DEF_T_UP_TO     = 60_000_000;
    localparam int unsigned DEF_UP_FILT     = 16;
    localparam int unsigned DEF_DROP_FILT   = 16;
    localparam int unsigned DEF_MAX_RETRY   = 3;
    localparam int unsigned DEF_CNT_W       = 28;

endpackage

// File: rtl/sfp_level_filter.sv
// rtl/sfp_level_filter.sv - run-length filter flagging N consecutive high or low samples
module sfp_level_filter #(
    parameter int unsigned N = 16
) (
    input  logic aurora_axis_aclk,
    input  logic aurora_axis_aresetn,
    input  logic level,
    output logic stable_high,
    output logic stable_low
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW:0] N_L = (CW + 1)'(N);

    logic          run_lvl;
    logic [CW-1:0] run_cnt;
    logic [CW:0]   run_len;

    // run_len includes the current sample, so the flag is valid in the cycle the Nth sample arrives
    assign run_len     = (level == run_lvl) ? ({1'b0, run_cnt} + (CW + 1)'(1)) : (CW + 1)'(1);
    assign stable_high = level && (run_len >= N_L);
    assign stable_low  = !level && (run_len >= N_L);

    always_ff @(posedge aurora_axis_aclk or negedge aurora_axis_aresetn) begin
        if (!aurora_axis_aresetn) begin
            run_lvl <= 1'b0;
            run_cnt <= '0;
        end else begin
            run_lvl <= level;
            run_cnt <= (run_len > N_L) ? CW'(N) : run_len[CW-1:0];
        end
    end

endmodule

// File: rtl/sfp_link_supervisor.sv
// rtl/sfp_link_supervisor.sv - Aurora reset_pb/pma_init sequencer with link-up watch and retry
module sfp_link_supervisor
    import sfp_link_pkg::*;
#(
    parameter int unsigned T_PB_ON     = DEF_T_PB_ON,
    parameter int unsigned T_PMA_ON    = DEF_T_PMA_ON,
    parameter int unsigned T_PMA_OFF   = DEF_T_PMA_OFF,
    parameter int unsigned T_PB_OFF    = DEF_T_PB_OFF,
    parameter int unsigned T_INIT_DONE = DEF_T_INIT_DONE,
    parameter int unsigned T_UP_TO     = DEF_T_UP_TO,
    parameter int unsigned UP_FILT     = DEF_UP_FILT,
    parameter int unsigned DROP_FILT   = DEF_DROP_FILT,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic       aurora_axis_aclk,
    input  logic       aurora_axis_aresetn,
    input  logic       i_channel_up,
    input  logic       i_retrain,
    output logic       reset_pb,
    output logic       pma_init,
    output logic       o_aurora_init_flag,
    output logic       o_link_ok,
    output logic       o_link_fail,
    output logic [3:0] o_retry_cnt,
    output logic [2:0] o_state
);

    if (!(T_PB_ON < T_PMA_ON && T_PMA_ON < T_PMA_OFF && T_PMA_OFF < T_PB_OFF &&
          T_PB_OFF < T_INIT_DONE && 64'(T_INIT_DONE) < (64'd1 << CNT_W) &&
          64'(T_UP_TO) < (64'd1 << CNT_W) && MAX_RETRY <= 15)) begin : g_bad_params
        $error("sfp_link_supervisor: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] PB_ON     = CNT_W'(T_PB_ON);
    localparam logic [CNT_W-1:0] PMA_ON    = CNT_W'(T_PMA_ON);
    localparam logic [CNT_W-1:0] PMA_OFF   = CNT_W'(T_PMA_OFF);
    localparam logic [CNT_W-1:0] PB_OFF    = CNT_W'(T_PB_OFF);
    localparam logic [CNT_W-1:0] INIT_DONE = CNT_W'(T_INIT_DONE);
    localparam logic [CNT_W-1:0] UP_TO     = CNT_W'(T_UP_TO);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;
    localparam logic [3:0]       MAX_R     = 4'(MAX_RETRY);

    sfp_state_e       state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [3:0]       retry_cnt, retry_nxt;
    logic             reset_pb_nxt, pma_init_nxt;
    logic             retry_take, retrain_hit;
    logic             up_stable, drop_stable, up_unused_low, drop_unused_high;

    sfp_level_filter #(.N(UP_FILT)) u_up_filter (
        .aurora_axis_aclk    (aurora_axis_aclk),
        .aurora_axis_aresetn (aurora_axis_aresetn),
        .level               (i_channel_up),
        .stable_high         (up_stable),
        .stable_low          (up_unused_low)
    );

    sfp_level_filter #(.N(DROP_FILT)) u_drop_filter (
        .aurora_axis_aclk    (aurora_axis_aclk),
        .aurora_axis_aresetn (aurora_axis_aresetn),
        .level               (i_channel_up),
        .stable_high         (drop_unused_high),
        .stable_low          (drop_stable)
    );

    always_comb begin
        state_nxt    = state;
        retry_nxt    = retry_cnt;
        reset_pb_nxt = 1'b0;
        pma_init_nxt = 1'b0;
        retry_take   = 1'b0;
        retrain_hit  = i_retrain && (state != ST_IDLE);
        case (state)
            ST_IDLE: state_nxt = ST_SEQ;
            ST_SEQ: begin
                if (timer == INIT_DONE) begin
                    state_nxt = ST_WAIT_UP;
                end else begin
                    reset_pb_nxt = (timer >= PB_ON) && (timer < PB_OFF);
                    pma_init_nxt = (timer >= PMA_ON) && (timer < PMA_OFF);
                end
            end
            ST_WAIT_UP: begin
                if (up_stable) begin
                    state_nxt = ST_LINK_UP;
                    retry_nxt = 4'd0;
                end else if (timer == UP_TO) begin
                    retry_take = 1'b1;
                end
            end
            ST_LINK_UP: retry_take = drop_stable;
            ST_FAIL:    reset_pb_nxt = 1'b1;
            default:    state_nxt = ST_IDLE;
        endcase
        if (retry_take) begin
            if (retry_cnt == MAX_R) begin
                state_nxt    = ST_FAIL;
                reset_pb_nxt = 1'b1;
            end else begin
                state_nxt = ST_SEQ;
                retry_nxt = retry_cnt + 4'd1;
            end
        end
        // a retrain overrides every other outcome in the same cycle
        if (retrain_hit) begin
            state_nxt    = ST_SEQ;
            retry_nxt    = 4'd0;
            reset_pb_nxt = 1'b0;
            pma_init_nxt = 1'b0;
        end
        if (retrain_hit || (state_nxt != state)) begin
            timer_nxt = '0;
        end else if ((state == ST_SEQ) || (state == ST_WAIT_UP)) begin
            timer_nxt = (timer == TIMER_MAX) ? timer : timer + CNT_W'(1);
        end else begin
            timer_nxt = timer;
        end
    end

    always_ff @(posedge aurora_axis_aclk or negedge aurora_axis_aresetn) begin
        if (!aurora_axis_aresetn) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry_cnt <= 4'd0;
            reset_pb  <= 1'b0;
            pma_init  <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            reset_pb  <= reset_pb_nxt;
            pma_init  <= pma_init_nxt;
        end
    end

    assign o_aurora_init_flag = (state == ST_WAIT_UP) || (state == ST_LINK_UP);
    assign o_link_ok          = (state == ST_LINK_UP);
    assign o_link_fail        = (state == ST_FAIL);
    assign o_retry_cnt        = retry_cnt;
    assign o_state            = state;

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// tb/tb_sfp_link_supervisor.sv - directed-vector bench for sfp_link_supervisor
module tb_sfp_link_supervisor;

    logic       clk = 1'b0;
    logic       aresetn;
    logic       channel_up;
    logic       retrain;
    logic       reset_pb, pma_init, init_flag, link_ok, link_fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int k;
        int st;
        int rpb;
        int pma;
        int flag;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    sfp_link_supervisor #(
        .T_PB_ON(4), .T_PMA_ON(8), .T_PMA_OFF(40), .T_PB_OFF(50), .T_INIT_DONE(60),
        .T_UP_TO(30), .UP_FILT(4), .DROP_FILT(3), .MAX_RETRY(2), .CNT_W(28)
    ) dut (
        .aurora_axis_aclk    (clk),
        .aurora_axis_aresetn (aresetn),
        .i_channel_up        (channel_up),
        .i_retrain           (retrain),
        .reset_pb            (reset_pb),
        .pma_init            (pma_init),
        .o_aurora_init_flag  (init_flag),
        .o_link_ok           (link_ok),
        .o_link_fail         (link_fail),
        .o_retry_cnt         (retry_cnt),
        .o_state             (state)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_reset_pb"}, int'(reset_pb), 0);
        chk({tag, "_pma_init"}, int'(pma_init), 0);
        chk({tag, "_init_flag"}, int'(init_flag), 0);
        chk({tag, "_link_ok"}, int'(link_ok), 0);
        chk({tag, "_link_fail"}, int'(link_fail), 0);
        chk({tag, "_retry"}, int'(retry_cnt), 0);
    endtask

    // called right after reset release at a falling edge; k counts rising edges since release
    task automatic apply_table(input string tag);
        int cur;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            ticks(tbl[i].k - cur);
            cur = tbl[i].k;
            chk($sformatf("%s_k%0d_state", tag, cur), int'(state), tbl[i].st);
            chk($sformatf("%s_k%0d_reset_pb", tag, cur), int'(reset_pb), tbl[i].rpb);
            chk($sformatf("%s_k%0d_pma_init", tag, cur), int'(pma_init), tbl[i].pma);
            chk($sformatf("%s_k%0d_init_flag", tag, cur), int'(init_flag), tbl[i].flag);
        end
    endtask

    initial begin
        // SEQ timer at edge k is k-1; outputs lag the timer window by one cycle
        tbl[0]  = '{0,  0, 0, 0, 0};
        tbl[1]  = '{1,  1, 0, 0, 0};
        tbl[2]  = '{5,  1, 0, 0, 0};
        tbl[3]  = '{6,  1, 1, 0, 0};
        tbl[4]  = '{9,  1, 1, 0, 0};
        tbl[5]  = '{10, 1, 1, 1, 0};
        tbl[6]  = '{41, 1, 1, 1, 0};
        tbl[7]  = '{42, 1, 1, 0, 0};
        tbl[8]  = '{51, 1, 1, 0, 0};
        tbl[9]  = '{52, 1, 0, 0, 0};
        tbl[10] = '{61, 1, 0, 0, 0};
        tbl[11] = '{62, 2, 0, 0, 1};

        aresetn    = 1'b0;
        channel_up = 1'b0;
        retrain    = 1'b0;
        @(negedge clk);
        ticks(2);
        chk_idle_outputs("rst");
        aresetn = 1'b1;
        apply_table("seq1");

        // link comes up 10 cycles into WAIT_UP
        ticks(10);
        channel_up = 1'b1;
        ticks(3);
        chk("up_filt3_link_ok", int'(link_ok), 0);
        tick();
        chk("up_filt4_link_ok", int'(link_ok), 1);
        chk("up_state", int'(state), 3);
        chk("up_retry", int'(retry_cnt), 0);
        chk("up_init_flag", int'(init_flag), 1);
        chk("up_reset_pb", int'(reset_pb), 0);

        // short drop is filtered, full drop retries
        channel_up = 1'b0;
        ticks(2);
        chk("drop2_state", int'(state), 3);
        channel_up = 1'b1;
        tick();
        chk("drop2_recover_state", int'(state), 3);
        channel_up = 1'b0;
        ticks(2);
        chk("drop3_pre_state", int'(state), 3);
        tick();
        chk("drop3_state", int'(state), 1);
        chk("drop3_retry", int'(retry_cnt), 1);
        chk("drop3_link_ok", int'(link_ok), 0);

        // retrain on the exact timeout cycle wins
        ticks(60);
        chk("rt_seq_end_state", int'(state), 1);
        tick();
        chk("rt_wait_state", int'(state), 2);
        ticks(30);
        chk("rt_timeout_cycle_state", int'(state), 2);
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        chk("rt_timeout_state", int'(state), 1);
        chk("rt_timeout_retry", int'(retry_cnt), 0);

        // asynchronous reset mid-sequence
        ticks(20);
        chk("mid_reset_pb", int'(reset_pb), 1);
        chk("mid_pma_init", int'(pma_init), 1);
        aresetn = 1'b0;
        #1;
        chk_idle_outputs("async_rst");
        ticks(2);
        aresetn = 1'b1;
        apply_table("seq2");

        // three timeouts end in FAIL
        ticks(30);
        chk("to1_pre_state", int'(state), 2);
        tick();
        chk("to1_state", int'(state), 1);
        chk("to1_retry", int'(retry_cnt), 1);
        ticks(61);
        chk("to2_wait_state", int'(state), 2);
        ticks(31);
        chk("to2_state", int'(state), 1);
        chk("to2_retry", int'(retry_cnt), 2);
        ticks(61);
        chk("to3_wait_state", int'(state), 2);
        ticks(31);
        chk("fail_state", int'(state), 4);
        chk("fail_link_fail", int'(link_fail), 1);
        chk("fail_reset_pb", int'(reset_pb), 1);
        chk("fail_pma_init", int'(pma_init), 0);
        chk("fail_init_flag", int'(init_flag), 0);
        ticks(5);
        chk("fail_hold_state", int'(state), 4);
        chk("fail_hold_reset_pb", int'(reset_pb), 1);

        // retrain out of FAIL
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        chk("rt_fail_state", int'(state), 1);
        chk("rt_fail_retry", int'(retry_cnt), 0);
        chk("rt_fail_link_fail", int'(link_fail), 0);
        chk("rt_fail_reset_pb", int'(reset_pb), 0);
        ticks(4);
        chk("rt_fail_t4_reset_pb", int'(reset_pb), 0);
        tick();
        chk("rt_fail_t5_reset_pb", int'(reset_pb), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
